// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button sync/debounce and IDLE/RUN/PAUSE/CLEAR control for the stopwatch counter.
// Define STOPWATCH_LAP_EN to add the btn_lap input and Freeze display-hold output.
module stopwatch_ctrl #(
    parameter int CLK_HZ = 10000000,
    parameter int DEB_MS = 20,
    parameter int CLR_MS = 2
) (
    input  logic       MHz,
    input  logic       Reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_speed,
`ifdef STOPWATCH_LAP_EN
    input  logic       btn_lap,
    output logic       Freeze,
`endif
    output logic       Enable,
    output logic       Speed,
    output logic       ClrN,
    output logic [1:0] State
);

    localparam int TDIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 2;
    localparam int TW = $clog2(TDIV);
    localparam logic [TW-1:0] TMAX = TW'(TDIV - 1);
    localparam logic [7:0] DEB = 8'(DEB_MS);
    localparam logic [7:0] CLR = 8'(CLR_MS);

`ifdef STOPWATCH_LAP_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_CLEAR = 2'b11;

    logic [TW-1:0] tcnt;
    logic          ms_tick;
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] lvl;
    logic [NB-1:0] lvl_q;
    logic [NB-1:0] press;
    logic [7:0]    deb_cnt [NB];
    logic [7:0]    dwell;
    logic [7:0]    dwell_n;
    logic [1:0]    nstate;
    logic          start_p;
    logic          clear_p;
    logic          speed_p;

`ifdef STOPWATCH_LAP_EN
    assign raw = {btn_lap, btn_speed, btn_clear, btn_start};
`else
    assign raw = {btn_speed, btn_clear, btn_start};
`endif

    assign ms_tick = (tcnt == TMAX);
    assign press   = lvl & ~lvl_q;
    assign start_p = press[0];
    assign clear_p = press[1];
    assign speed_p = press[2];

    // 1 ms tick: free-running divider, pulse in the wrap cycle
    always_ff @(posedge MHz) begin
        if (!Reset) begin
            tcnt <= '0;
        end else if (ms_tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // Two-flop synchroniser for every raw button
    always_ff @(posedge MHz) begin
        if (!Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: level follows sync only after it has differed for DEB_MS full ticks
    always_ff @(posedge MHz) begin
        if (!Reset) begin
            lvl <= '0;
            for (int i = 0; i < NB; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (ms_tick) begin
                    if (deb_cnt[i] == DEB) begin
                        lvl[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // Previous debounced level, for rising-edge press pulses
    always_ff @(posedge MHz) begin
        if (!Reset) begin
            lvl_q <= '0;
        end else begin
            lvl_q <= lvl;
        end
    end

    // Next state; clear beats start except in RUN, where clear is ignored
    always_comb begin
        nstate  = State;
        dwell_n = dwell;
        case (State)
            S_IDLE, S_PAUSE: begin
                if (clear_p) begin
                    nstate = S_CLEAR;
                end else if (start_p) begin
                    nstate = S_RUN;
                end
            end
            S_RUN: begin
                if (start_p) begin
                    nstate = S_PAUSE;
                end
            end
            default: begin
                if (ms_tick) begin
                    if (dwell == CLR) begin
                        nstate = S_IDLE;
                    end else begin
                        dwell_n = dwell + 8'd1;
                    end
                end
            end
        endcase
        if (nstate == S_CLEAR && State != S_CLEAR) begin
            dwell_n = '0;
        end
    end

    // State and registered output decode; reset lands in CLEAR for a full clear pulse
    always_ff @(posedge MHz) begin
        if (!Reset) begin
            State  <= S_CLEAR;
            Enable <= 1'b1;
            ClrN   <= 1'b0;
            Speed  <= 1'b1;
            dwell  <= '0;
        end else begin
            State  <= nstate;
            Enable <= (nstate != S_RUN);
            ClrN   <= (nstate != S_CLEAR);
            dwell  <= dwell_n;
            if (speed_p) begin
                Speed <= ~Speed;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Lap freeze: toggles in RUN, dropped by lap in PAUSE and on entry to CLEAR
    always_ff @(posedge MHz) begin
        if (!Reset) begin
            Freeze <= 1'b0;
        end else if (nstate == S_CLEAR && State != S_CLEAR) begin
            Freeze <= 1'b0;
        end else if (State == S_RUN && press[3]) begin
            Freeze <= ~Freeze;
        end else if (State == S_PAUSE && press[3]) begin
            Freeze <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: table vectors, corner sequences and random buttons
// checked against a behavioural model of the stopwatch control stage.
module tb_stopwatch_ctrl;

    localparam int TD  = 10;
    localparam int DEB = 4;
    localparam int CLR = 2;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] CLRS  = 2'b11;

    logic       MHz = 1'b0;
    logic       Reset = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_speed = 1'b0;
    logic       Enable;
    logic       Speed;
    logic       ClrN;
    logic [1:0] State;
`ifdef STOPWATCH_LAP_EN
    logic       btn_lap = 1'b0;
    logic       Freeze;
`endif

    int vectors = 0;
    int miscompares = 0;

    stopwatch_ctrl #(
        .CLK_HZ(10000),
        .DEB_MS(DEB),
        .CLR_MS(CLR)
    ) dut (
        .MHz(MHz),
        .Reset(Reset),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .btn_speed(btn_speed),
`ifdef STOPWATCH_LAP_EN
        .btn_lap(btn_lap),
        .Freeze(Freeze),
`endif
        .Enable(Enable),
        .Speed(Speed),
        .ClrN(ClrN),
        .State(State)
    );

    always #5 MHz = ~MHz;

    // Reference model: ms ticks by cycle count, sync as a 2-deep history,
    // debounce as "ticks spent disagreeing", FSM from the transition rules.
    int         m_cyc = 0;
    logic [2:0] m_h0 = '0;
    logic [2:0] m_h1 = '0;
    logic [2:0] m_lvl = '0;
    logic [2:0] m_prev = '0;
    int         m_dis [3] = '{0, 0, 0};
    logic [1:0] m_st = CLRS;
    int         m_seen = 0;
    logic       m_spd = 1'b1;

    always @(posedge MHz) begin : model
        logic [2:0] raw;
        logic [2:0] syn;
        logic [2:0] p;
        logic [2:0] lvl_n;
        int         d_n [3];
        logic [1:0] ns;
        int         seen_n;
        bit         tick;
        raw = {btn_speed, btn_clear, btn_start};
        if (!Reset) begin
            m_cyc  <= 0;
            m_h0   <= '0;
            m_h1   <= '0;
            m_lvl  <= '0;
            m_prev <= '0;
            m_dis  <= '{0, 0, 0};
            m_st   <= CLRS;
            m_seen <= 0;
            m_spd  <= 1'b1;
        end else begin
            tick  = (m_cyc % TD) == TD - 1;
            syn   = m_h1;
            lvl_n = m_lvl;
            for (int i = 0; i < 3; i++) begin
                d_n[i] = m_dis[i];
                if (syn[i] == m_lvl[i]) begin
                    d_n[i] = 0;
                end else if (tick) begin
                    d_n[i] = d_n[i] + 1;
                    if (d_n[i] > DEB) begin
                        lvl_n[i] = syn[i];
                        d_n[i]   = 0;
                    end
                end
            end
            p      = m_lvl & ~m_prev;
            ns     = m_st;
            seen_n = m_seen;
            if (m_st == IDLE || m_st == PAUSE) begin
                if (p[1]) ns = CLRS;
                else if (p[0]) ns = RUN;
            end else if (m_st == RUN) begin
                if (p[0]) ns = PAUSE;
            end else if (tick) begin
                seen_n = m_seen + 1;
                if (seen_n > CLR) ns = IDLE;
            end
            if (ns == CLRS && m_st != CLRS) seen_n = 0;
            m_cyc  <= m_cyc + 1;
            m_h0   <= raw;
            m_h1   <= m_h0;
            m_lvl  <= lvl_n;
            m_prev <= m_lvl;
            m_dis  <= d_n;
            m_st   <= ns;
            m_seen <= seen_n;
            m_spd  <= m_spd ^ p[2];
        end
    end

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b want %b (state,en,clrn,spd)", name, got, exp);
        end
    endtask

    task automatic check_rng(input string name, input int got, input int lo, input int hi);
        vectors++;
        if (got < lo || got > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d..%0d", name, got, lo, hi);
        end
    endtask

    // One cycle: wait for the falling edge, then compare against the model
    task automatic step();
        @(negedge MHz);
        check("model", {State, Enable, ClrN, Speed},
              {m_st, m_st != RUN, m_st != CLRS, m_spd});
    endtask

    typedef struct {
        bit         st;
        bit         cl;
        bit         sp;
        int         hold;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int n;
        int bad;
        int rises;
        int low;
        logic [1:0] prev;
        int hold [3];
        logic [2:0] lv;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 80, 5'b01011};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 80, 5'b01011};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 80, 5'b01011};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 80, 5'b01010};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 80, 5'b01010};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 80, 5'b10110};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 80, 5'b10110};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 80, 5'b10111};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 80, 5'b10111};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 60, 5'b11101};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 80, 5'b00111};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 80, 5'b00110};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 80, 5'b00110};

        // Reset held low for 3 cycles, then the reset clear pulse expires
        repeat (3) begin
            step();
            check("reset_vals", {State, Enable, ClrN, Speed}, 5'b11101);
        end
        Reset = 1'b1;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (State == IDLE) break;
        end
        check_rng("reset_clear_len", n, 20, 30);
        check("after_reset", {State, Enable, ClrN, Speed}, 5'b00111);

        // Start press latency from raw rise to RUN
        btn_start = 1'b1;
        n = 0;
        while (n <= 70) begin
            step();
            if (State == RUN) break;
            n++;
        end
        check_rng("start_latency", n, 41, 52);
        check_rng("run_enable", int'(Enable), 0, 0);

        // Table: start release, clear ignored in RUN, pause, clear, speed
        foreach (tbl[i]) begin
            btn_start = tbl[i].st;
            btn_clear = tbl[i].cl;
            btn_speed = tbl[i].sp;
            repeat (tbl[i].hold) step();
            check($sformatf("tbl%0d", i), {State, Enable, ClrN, Speed}, tbl[i].exp);
        end

        // Bouncing start never registers; the stable press registers once
        btn_start = 1'b0;
        bad = 0;
        for (int k = 0; k < 13; k++) begin
            btn_start = ~btn_start;
            repeat (15) begin
                step();
                if (State != IDLE) bad++;
            end
        end
        check_rng("bounce_quiet", bad, 0, 0);
        btn_start = 1'b1;
        rises = 0;
        prev = State;
        repeat (80) begin
            step();
            if (prev == IDLE && State == RUN) rises++;
            prev = State;
        end
        check_rng("bounce_one_run", rises, 1, 1);
        btn_start = 1'b0;
        repeat (80) step();
        btn_start = 1'b1;
        repeat (80) step();
        btn_start = 1'b0;
        repeat (80) step();
        check_rng("pause_reached", int'(State), 2, 2);

        // Start and clear together in PAUSE: clear wins, RUN never seen
        btn_start = 1'b1;
        btn_clear = 1'b1;
        bad = 0;
        low = 0;
        repeat (130) begin
            step();
            if (State == RUN) bad++;
            if (!ClrN) low++;
        end
        check_rng("sim_no_run", bad, 0, 0);
        check_rng("sim_clear_width", low, 20, 30);
        check_rng("sim_back_idle", int'(State), 0, 0);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        repeat (80) step();

        // Random bouncy/long presses with rare resets, model-checked each cycle
        lv = '0;
        hold = '{0, 0, 0};
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    lv[b] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 1) == 0) hold[b] = int'($urandom_range(1, 12));
                    else hold[b] = int'($urandom_range(40, 120));
                end else begin
                    hold[b]--;
                end
            end
            {btn_speed, btn_clear, btn_start} = lv;
            Reset = ($urandom_range(0, 799) != 0);
            step();
        end
        Reset = 1'b1;
        {btn_speed, btn_clear, btn_start} = 3'b000;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
